// File: rtl/seg7_scan_if.sv
// Scanned seven-segment bus plus the decoded read-back signals.
// Latency: none, wiring only.
// Backpressure: none; the display bus is sampled unconditionally every clock.
interface seg7_scan_if #(
    parameter int NDIG = 2
);
    logic [6:0]        seg7;
    logic [NDIG-1:0]   dig_sel;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic              upd;
    logic [2:0]        upd_idx;
    logic              err;

    // Display side drives segments/selects and observes the decoded result.
    modport master (
        output seg7, dig_sel,
        input  digits, valid, upd, upd_idx, err
    );

    // Decoder side.
    modport slave (
        input  seg7, dig_sel,
        output digits, valid, upd, upd_idx, err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit codes from a scanned seven-segment bus with per-digit debounce.
// Latency: commit registered on the STABLE-th matching sample, visible the next cycle.
// Backpressure: none; every clock is a potential sample, ignored unless select is one-hot.
module seg7_scan_decoder #(
    parameter int NDIG   = 2,
    parameter int STABLE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int          CW  = $clog2(STABLE + 1);
    localparam logic [CW-1:0] STB = CW'(STABLE);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [6:0]        cand [NDIG];
    logic [CW-1:0]     cnt  [NDIG];
    logic [CW-1:0]     cnt_nxt [NDIG];
    logic [4*NDIG-1:0] digits_q;
    logic [NDIG-1:0]   valid_q;
    logic              upd_q;
    logic [2:0]        upd_idx_q;
    logic              err_q;

    logic [NDIG-1:0]   sel;
    logic              sel_onehot;
    logic [NDIG-1:0]   hit;
    logic [NDIG-1:0]   match;
    logic [NDIG-1:0]   commit;
    logic [NDIG-1:0]   changed;
    logic [3:0]        code;

    // Pattern-to-code lookup; anything unrecognised is flagged as 4'hE.
    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 4'h0;
            7'b0110000: decode = 4'h1;
            7'b1101101: decode = 4'h2;
            7'b1111001: decode = 4'h3;
            7'b0110011: decode = 4'h4;
            7'b1011011: decode = 4'h5;
            7'b1011111: decode = 4'h6;
            7'b1110000: decode = 4'h7;
            7'b1111111: decode = 4'h8;
            7'b1111011: decode = 4'h9;
            7'b0000000: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    // A cycle counts as a sample only when exactly one select line is low.
    always_comb begin
        sel        = ~bus.dig_sel;
        sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        hit        = sel_onehot ? sel : '0;
    end

    // Per-digit run counting and commit detection. A mismatch restarting at 1
    // only commits when STABLE is 1, so the !match term covers that case.
    always_comb begin
        code = decode(bus.seg7);
        for (int k = 0; k < NDIG; k++) begin
            match[k]   = (bus.seg7 == cand[k]);
            cnt_nxt[k] = match[k] ? ((cnt[k] == STB) ? STB : cnt[k] + 1'b1) : ONE;
            commit[k]  = hit[k] && (cnt_nxt[k] == STB) && ((cnt[k] < STB) || !match[k]);
            changed[k] = commit[k] && (!valid_q[k] || (digits_q[4*k +: 4] != code));
        end
    end

    // Per-digit state update plus the single-cycle upd/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDIG; k++) begin
                cand[k] <= '0;
                cnt[k]  <= '0;
            end
            digits_q  <= '1;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                if (hit[k]) begin
                    cand[k] <= bus.seg7;
                    cnt[k]  <= cnt_nxt[k];
                end
                if (commit[k]) begin
                    digits_q[4*k +: 4] <= code;
                    valid_q[k]         <= 1'b1;
                end
                if (changed[k]) begin
                    upd_q     <= 1'b1;
                    upd_idx_q <= 3'(k);
                    err_q     <= (code == 4'hE);
                end
            end
        end
    end

    assign bus.digits  = digits_q;
    assign bus.valid   = valid_q;
    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: fixed vector table, hand sequences and random scan vs a run-length model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives a new sample every cycle.
module tb_seg7_scan_decoder;
    localparam int NDIG   = 2;
    localparam int STABLE = 3;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seg7_scan_if #(.NDIG(NDIG)) bus ();

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: run length of identical samples per digit
    logic [6:0]        m_pat [NDIG];
    int                m_run [NDIG];
    logic [4*NDIG-1:0] m_digits;
    logic [NDIG-1:0]   m_valid;
    logic              m_upd;
    logic [2:0]        m_idx;
    logic              m_err;

    logic [6:0] glyph [10];

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        ref_decode = 4'hE;
        if (p == 7'b0000000) ref_decode = 4'hF;
        for (int i = 0; i < 10; i++)
            if (glyph[i] == p) ref_decode = 4'(i);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDIG; k++) begin
            m_pat[k] = 7'b0000000;
            m_run[k] = 0;
        end
        m_digits = '1;
        m_valid  = '0;
        m_upd    = 1'b0;
        m_idx    = 3'd0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] seg, input logic [NDIG-1:0] sel);
        int nlow;
        int k;
        logic [3:0] c;
        nlow = 0;
        k = 0;
        m_upd = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (!sel[i]) begin
                nlow++;
                k = i;
            end
        if (nlow == 1) begin
            if (seg == m_pat[k]) m_run[k]++;
            else begin
                m_pat[k] = seg;
                m_run[k] = 1;
            end
            if (m_run[k] == STABLE) begin
                c = ref_decode(seg);
                if (!m_valid[k] || m_digits[4*k +: 4] != c) begin
                    m_upd = 1'b1;
                    m_idx = 3'(k);
                    m_err = (c == 4'hE);
                end
                m_digits[4*k +: 4] = c;
                m_valid[k] = 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_edge(input logic [6:0] seg, input logic [NDIG-1:0] sel);
        bus.seg7    = seg;
        bus.dig_sel = sel;
        @(posedge clk);
        model_step(seg, sel);
        #1;
    endtask

    task automatic cycle_model(input logic [6:0] seg, input logic [NDIG-1:0] sel, input string tag);
        drive_edge(seg, sel);
        chk({tag, ".digits"},  32'(bus.digits),  32'(m_digits));
        chk({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
        chk({tag, ".upd"},     32'(bus.upd),     32'(m_upd));
        chk({tag, ".upd_idx"}, 32'(bus.upd_idx), 32'(m_idx));
        chk({tag, ".err"},     32'(bus.err),     32'(m_err));
    endtask

    typedef struct {
        logic [6:0]        seg;
        logic [NDIG-1:0]   sel;
        logic [4*NDIG-1:0] digits;
        logic [NDIG-1:0]   valid;
        logic              upd;
        logic [2:0]        idx;
        logic              err;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [6:0] s, input logic [1:0] d, input logic [7:0] dg,
                                input logic [1:0] v, input logic u, input logic [2:0] i);
        vec_t r;
        r.seg = s; r.sel = d; r.digits = dg; r.valid = v; r.upd = u; r.idx = i; r.err = 1'b0;
        return r;
    endfunction

    logic [6:0] cur [NDIG];
    logic [6:0] pool [13];
    logic [NDIG-1:0] rsel;
    int r;

    initial begin
        errors = 0;
        checks = 0;
        glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
        glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
        glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
        glyph[9] = 7'b1111011;

        // basic commit of 5 on digit 0, then a hold
        for (int i = 0; i < 2; i++) vecs.push_back(mk(7'b1011011, 2'b10, 8'hFF, 2'b00, 1'b0, 3'd0));
        vecs.push_back(mk(7'b1011011, 2'b10, 8'hF5, 2'b01, 1'b1, 3'd0));
        vecs.push_back(mk(7'b1011011, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        // glitch rejection: 0,0,1,0,0,0 -> only the last edge commits 0
        vecs.push_back(mk(7'b1111110, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        vecs.push_back(mk(7'b1111110, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        vecs.push_back(mk(7'b0110000, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        vecs.push_back(mk(7'b1111110, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        vecs.push_back(mk(7'b1111110, 2'b10, 8'hF5, 2'b01, 1'b0, 3'd0));
        vecs.push_back(mk(7'b1111110, 2'b10, 8'hF0, 2'b01, 1'b1, 3'd0));
        // interleaved scan: digit 1 shows 1, digit 0 shows 3
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(7'b0110000, 2'b01, 8'hF0, 2'b01, 1'b0, 3'd0));
            vecs.push_back(mk(7'b1111001, 2'b10, 8'hF0, 2'b01, 1'b0, 3'd0));
        end
        vecs.push_back(mk(7'b0110000, 2'b01, 8'h10, 2'b11, 1'b1, 3'd1));
        vecs.push_back(mk(7'b1111001, 2'b10, 8'h13, 2'b11, 1'b1, 3'd0));

        rst_n = 1'b0;
        bus.seg7 = 7'b0;
        bus.dig_sel = '1;
        model_reset();
        #12;
        chk("reset.digits",  32'(bus.digits),  32'hFF);
        chk("reset.valid",   32'(bus.valid),   32'h0);
        chk("reset.upd",     32'(bus.upd),     32'h0);
        chk("reset.upd_idx", 32'(bus.upd_idx), 32'h0);
        chk("reset.err",     32'(bus.err),     32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive_edge(vecs[i].seg, vecs[i].sel);
            chk($sformatf("vec%0d.digits", i),  32'(bus.digits),  32'(vecs[i].digits));
            chk($sformatf("vec%0d.valid", i),   32'(bus.valid),   32'(vecs[i].valid));
            chk($sformatf("vec%0d.upd", i),     32'(bus.upd),     32'(vecs[i].upd));
            chk($sformatf("vec%0d.upd_idx", i), 32'(bus.upd_idx), 32'(vecs[i].idx));
            chk($sformatf("vec%0d.err", i),     32'(bus.err),     32'(vecs[i].err));
        end

        // asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("arst.digits", 32'(bus.digits), 32'hFF);
        chk("arst.valid",  32'(bus.valid),  32'h0);
        chk("arst.upd",    32'(bus.upd),    32'h0);
        model_reset();
        #2 rst_n = 1'b1;

        // invalid selects mid-run do not disturb the count
        cycle_model(7'b1011011, 2'b10, "inv.s1");
        cycle_model(7'b1011011, 2'b10, "inv.s2");
        cycle_model(7'b0110000, 2'b00, "inv.both");
        for (int i = 0; i < 5; i++) cycle_model(7'(i * 13), 2'b11, "inv.none");
        chk("inv.digits_before", 32'(bus.digits), 32'hFF);
        cycle_model(7'b1011011, 2'b10, "inv.s3");
        chk("inv.commit", 32'(bus.digits), 32'hF5);
        chk("inv.upd",    32'(bus.upd),    32'h1);

        // error code, then blank
        for (int i = 0; i < 3; i++) cycle_model(7'b0000001, 2'b10, "errc");
        chk("errc.digits", 32'(bus.digits), 32'hFE);
        chk("errc.err",    32'(bus.err),    32'h1);
        chk("errc.upd",    32'(bus.upd),    32'h1);
        cycle_model(7'b0000001, 2'b10, "errc.hold");
        chk("errc.err_hold", 32'(bus.err), 32'h0);
        for (int i = 0; i < 3; i++) cycle_model(7'b0000000, 2'b10, "blank");
        chk("blank.digits", 32'(bus.digits), 32'hFF);
        chk("blank.upd",    32'(bus.upd),    32'h1);
        chk("blank.err",    32'(bus.err),    32'h0);
        chk("blank.valid",  32'(bus.valid),  32'h1);

        // randomized scan with sticky per-digit patterns
        for (int i = 0; i < 10; i++) pool[i] = glyph[i];
        pool[10] = 7'b0000000;
        pool[11] = 7'b0000001;
        pool[12] = 7'b1010101;
        for (int k = 0; k < NDIG; k++) cur[k] = pool[$urandom_range(0, 12)];
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       rsel = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
            else if (r == 7) rsel = '1;
            else             rsel = '0;
            for (int k = 0; k < NDIG; k++)
                if ($urandom_range(0, 5) == 0) cur[k] = pool[$urandom_range(0, 12)];
            if (rsel == '1 || rsel == '0) cycle_model(7'($urandom), rsel, "rand");
            else cycle_model(rsel[0] ? cur[1] : cur[0], rsel, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
